// File: rtl/evm_pkg.sv
// Shared definitions for the EVM ballot-control and vote-counting datapath.
package evm_pkg;

   // Ballot-control FSM states.
   typedef enum logic [2:0] {
      VC_IDLE     = 3'd0,
      VC_ARMED    = 3'd1,
      VC_DEBOUNCE = 3'd2,
      VC_CAST     = 3'd3,
      VC_WAIT_REL = 3'd4
   } vc_state_t;

   // Default number of candidates and debounce depth.
   localparam int EVM_NUM_CAND = 4;
   localparam int EVM_DEBOUNCE = 16;

   // Width of each downstream per-candidate vote counter.
   localparam int EVM_CNT_W    = 4;

endpackage

// File: rtl/sync2.sv
// Two-flop synchroniser for asynchronous level inputs; clears to zero on reset.
module sync2 #(
   parameter int W = 1
) (
   input  logic         clk,
   input  logic         reset,
   input  logic [W-1:0] d,
   output logic [W-1:0] q
);

   logic [W-1:0] meta_q;
   logic [W-1:0] sync_q;

   // Two back-to-back capture stages to let metastability settle.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         meta_q <= '0;
         sync_q <= '0;
      end else begin
         meta_q <= d;
         sync_q <= meta_q;
      end
   end

   assign q = sync_q;

endmodule

// File: rtl/vote_controller.sv
// Ballot control: arms on a ballot release edge, debounces one candidate
// button and emits a single one-hot vote pulse per released ballot.
module vote_controller
   import evm_pkg::*;
#(
   parameter int NUM_CAND        = EVM_NUM_CAND,
   parameter int DEBOUNCE_CYCLES = EVM_DEBOUNCE
) (
   input  logic                clk,
   input  logic                reset,
   input  logic                ballot_en,
   input  logic [NUM_CAND-1:0] cand_btn,
   output logic [NUM_CAND-1:0] vote_en,
   output logic                ready,
   output logic                vote_done,
   output logic                err_multi
);

   localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
   localparam int SEL_W = $clog2(NUM_CAND);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

   vc_state_t           state_q, state_d;
   logic [CNT_W-1:0]    cnt_q, cnt_d;
   logic [SEL_W-1:0]    sel_q, sel_d;
   logic [NUM_CAND-1:0] sel_btn_q, sel_btn_d;
   logic                ballot_q;

   logic [NUM_CAND-1:0] btn_s;
   logic                ballot_rise;
   logic                btn_any;
   logic                btn_multi;
   logic                btn_onehot;
   logic [SEL_W-1:0]    btn_idx;

   sync2 #(.W(NUM_CAND)) u_btn_sync (
      .clk   (clk),
      .reset (reset),
      .d     (cand_btn),
      .q     (btn_s)
   );

   // ballot_q resets high so a release held through reset cannot arm a ballot.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) ballot_q <= 1'b1;
      else       ballot_q <= ballot_en;
   end

   assign ballot_rise = ballot_en & ~ballot_q;
   assign btn_any     = |btn_s;
   assign btn_multi   = |(btn_s & (btn_s - 1'b1));
   assign btn_onehot  = btn_any & ~btn_multi;

   // Index of the pressed button; only consumed when exactly one bit is set.
   always_comb begin
      btn_idx = '0;
      for (int i = 0; i < NUM_CAND; i++) begin
         if (btn_s[i]) btn_idx = SEL_W'(i);
      end
   end

   // Next-state logic: one debounced, single-button vote per armed ballot.
   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      sel_d     = sel_q;
      sel_btn_d = sel_btn_q;
      case (state_q)
         VC_IDLE: begin
            if (ballot_rise) state_d = VC_ARMED;
         end
         VC_ARMED: begin
            if (btn_onehot) begin
               sel_d     = btn_idx;
               sel_btn_d = btn_s;
               cnt_d     = CNT_W'(1);
               state_d   = VC_DEBOUNCE;
            end
         end
         VC_DEBOUNCE: begin
            if (btn_s == sel_btn_q) begin
               if (cnt_q == CNT_LAST) state_d = VC_CAST;
               else                   cnt_d   = cnt_q + 1'b1;
            end else begin
               // Release, bounce or a change of button restarts the selection.
               cnt_d   = '0;
               state_d = VC_ARMED;
            end
         end
         VC_CAST: begin
            cnt_d   = '0;
            state_d = VC_WAIT_REL;
         end
         VC_WAIT_REL: begin
            if (!btn_any) state_d = VC_IDLE;
         end
         default: state_d = VC_IDLE;
      endcase
   end

   // FSM and selection registers.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q   <= VC_IDLE;
         cnt_q     <= '0;
         sel_q     <= '0;
         sel_btn_q <= '0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         sel_q     <= sel_d;
         sel_btn_q <= sel_btn_d;
      end
   end

   // Pulse outputs come only from registered state so they cannot glitch.
   assign ready     = (state_q == VC_ARMED) || (state_q == VC_DEBOUNCE);
   assign vote_done = (state_q == VC_CAST);
   assign vote_en   = vote_done ? (NUM_CAND'(1) << sel_q) : '0;
   assign err_multi = ready & btn_multi;

endmodule

// File: doc/vote_controller.md
# vote_controller

Ballot-control stage directly upstream of the per-candidate vote counters in the EVM datapath. Takes the presiding officer's ballot-release signal and the raw candidate push-buttons, synchronises and debounces them, and enforces exactly one vote per released ballot. Emits a single-cycle, one-hot enable pulse that drives the `enable` input of the selected candidate's 4-bit counter.

## Interface
Parameters:
- `NUM_CAND`, 4: number of candidate buttons and counters; must be 2 or more.
- `DEBOUNCE_CYCLES`, 16: consecutive qualifying samples required before a vote is cast; must be 2 or more.

Ports:
- `clk`  in  1  single system clock; all logic is on its rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `ballot_en`  in  1  officer ballot release; synchronous to `clk`, level signal; a rising edge arms one vote.
- `cand_btn`  in  `NUM_CAND`  raw candidate buttons, asynchronous, active-high.
- `vote_en`  out  `NUM_CAND`  one-hot, one-cycle pulse to the chosen candidate counter's `enable`.
- `ready`  out  1  high while a ballot is armed and no vote has yet been cast (ARMED or DEBOUNCE).
- `vote_done`  out  1  one-cycle pulse, coincident with `vote_en`.
- `err_multi`  out  1  high while armed and more than one synchronised button is pressed.

## Operation
- **Button synchroniser:** each `cand_btn` bit passes through a 2-flop synchroniser (`btn_s`). The FSM sees only `btn_s`.
- **Ballot edge detector:** `ballot_en` is compared with a registered copy, `ballot_q`. `ballot_q` resets to 1, so a `ballot_en` held high through reset must go low and then high again before a ballot is armed.
- **FSM states:** IDLE, ARMED, DEBOUNCE, CAST, WAIT_REL.
  - IDLE: a rising edge on `ballot_en` moves to ARMED. Button activity is ignored.
  - ARMED: if `btn_s` is one-hot, capture its index into `sel` and the pattern into `sel_btn`, set `cnt` to 1, and go to DEBOUNCE. If `btn_s` is zero or has two or more bits set, stay in ARMED.
  - DEBOUNCE: if `btn_s` equals `sel_btn` and `cnt` equals `DEBOUNCE_CYCLES-1`, go to CAST. If `btn_s` equals `sel_btn` otherwise, increment `cnt`. Any other `btn_s` value (release, a different button, or an added button) returns to ARMED with `cnt` cleared. No vote is cast in that case.
  - CAST: lasts one cycle. `vote_en[sel]` and `vote_done` are high. The next state is always WAIT_REL.
  - WAIT_REL: when `btn_s` is zero, go to IDLE. A new ballot always needs a fresh `ballot_en` rising edge.
- **Ballot edges in other states:** a `ballot_en` rising edge outside IDLE is ignored. It is not queued.
- **Output decode:** `ready`, `vote_en` and `vote_done` are decoded from the registered state and `sel` only, so they are glitch-free. `err_multi` is combinational from the state and `btn_s`.
- **Widths:**
  - `cnt` is `$clog2(DEBOUNCE_CYCLES+1)` bits wide and never wraps.
  - `sel` is `$clog2(NUM_CAND)` bits wide.
- **Reset values:**
  - `reset` forces state IDLE, `cnt`=0, `sel`=0, `btn_s`=0 and `ballot_q`=1.
  - All outputs are 0.
  - Reset asserted during DEBOUNCE or CAST suppresses the pulse completely. A partial `vote_en` is never produced.

## Timing
- **Press-to-vote latency:** a button first sampled high at a `clk` edge appears on `btn_s` 2 cycles later. `vote_en` is high during the cycle after the `DEBOUNCE_CYCLES`-th consecutive qualifying `btn_s` sample. The first of those samples is the one taken in ARMED.
- **Ballot-to-ready latency:** `ballot_en` rising edge to `ready` high is 1 cycle.
- **CAST timing:** `vote_en` and `vote_done` are high for exactly 1 cycle per ballot. `ready` drops in the same cycle.
- **Simultaneous press and ballot release:** handled sequentially, in this order:
  1. The button is ignored in IDLE.
  2. The ballot is armed.
  3. The button is then evaluated in ARMED on the following cycle.
- **Button held into the next ballot:** a button held from the previous ballot keeps the FSM in WAIT_REL. No ballot can be armed until all buttons are released.

## Structure
- **Shared package `evm_pkg`:**
  - the state enum `vc_state_t` (IDLE, ARMED, DEBOUNCE, CAST, WAIT_REL);
  - default constants `EVM_NUM_CAND`=4 and `EVM_DEBOUNCE`=16;
  - `EVM_CNT_W`=4, the width of the downstream counter.
- **Sub-module `sync2`:** a parameterised-width 2-flop synchroniser with asynchronous active-high reset to 0. It is instantiated once, for `cand_btn`.

## Test plan
- **Normal vote:** reset, then `ballot_en` 0→1, then hold `cand_btn`=4'b0100 for 30 cycles → exactly one `vote_en`=4'b0100 pulse, with `vote_done` coincident, 2+16 cycles after the press. Release, then `ballot_en` low → state IDLE.
- **Bounce rejection:** armed, `cand_btn[1]` toggles every 5 cycles for 100 cycles, then stays high → no pulse during the bounce; one pulse on bit 1 after 16 stable samples.
- **Multiple press:** armed, `cand_btn`=4'b0011 for 40 cycles → `err_multi`=1, no `vote_en`. Then drop to 4'b0001 → vote on bit 0.
- **One vote per ballot:** after a cast, press `cand_btn[2]` again for 40 cycles with `ballot_en` still high → no second pulse. A second `ballot_en` rising edge is required.
- **Reset boundaries:**
  - Assert `reset` mid-DEBOUNCE with `cnt`=10 → all outputs 0 immediately; no pulse ever appears.
  - Release `reset` with `ballot_en` held high → `ready` stays 0 until `ballot_en` goes 0→1.
- **Parameter sweep:** `NUM_CAND`=8, `DEBOUNCE_CYCLES`=2 → a press on bit 7 gives `vote_en`=8'h80 at a latency of 2+2 cycles.
